// File: rtl/addr_fu_scheduler.sv
// Issue/writeback scheduler for the address adder and multiplier: A-register hazard
// blocking, single write-port slot reservation and write strobe timing.
module addr_fu_scheduler #(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 6,
    parameter int AREG_AW = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_issue_valid,
    input  logic                  i_issue_op,
    input  logic [AREG_AW-1:0]    i_issue_dest,
    input  logic [AREG_AW-1:0]    i_issue_j,
    input  logic [AREG_AW-1:0]    i_issue_k,
    input  logic                  i_use_j,
    input  logic                  i_use_k,
    input  logic                  i_flush,
    output logic                  o_issue_ready,
    output logic                  o_wr_en,
    output logic                  o_wr_sel,
    output logic [AREG_AW-1:0]    o_wr_addr,
    output logic [2**AREG_AW-1:0] o_a_busy,
    output logic [3:0]            o_inflight
);
    localparam int NREG  = 2**AREG_AW;
    localparam int DEPTH = 15;

    // slot_*[d] describes the write that will be on o_wr_* d cycles from now.
    logic [DEPTH:1]     slot_v, slot_v_nxt;
    logic [DEPTH:1]     slot_sel, slot_sel_nxt;
    logic [AREG_AW-1:0] slot_dest     [DEPTH:1];
    logic [AREG_AW-1:0] slot_dest_nxt [DEPTH:1];

    logic [NREG-1:0]    busy_nxt;
    logic [3:0]         inflight_nxt;
    logic               wr_en_nxt;
    logic               wr_sel_nxt;
    logic [AREG_AW-1:0] wr_addr_nxt;
    logic [3:0]         lat;
    logic               accept;

    // Landing in slot[lat] before the shift means landing on o_wr_* exactly in cycle lat.
    always_comb begin
        lat           = i_issue_op ? 4'(MUL_LAT) : 4'(ADD_LAT);
        o_issue_ready = !i_flush
                        && !o_a_busy[i_issue_dest]
                        && !(i_use_j && o_a_busy[i_issue_j])
                        && !(i_use_k && o_a_busy[i_issue_k])
                        && !slot_v[lat];
        accept        = i_issue_valid && o_issue_ready;
    end

    // NOTE: every variable gets its default (the plain shift) before any conditional
    // override, so this block stays purely combinational with no inferred latches.
    always_comb begin
        for (int d = 1; d < DEPTH; d++) begin
            slot_v_nxt[d]    = slot_v[d+1];
            slot_sel_nxt[d]  = slot_sel[d+1];
            slot_dest_nxt[d] = slot_dest[d+1];
        end
        slot_v_nxt[DEPTH]    = 1'b0;
        slot_sel_nxt[DEPTH]  = 1'b0;
        slot_dest_nxt[DEPTH] = '0;

        wr_en_nxt    = slot_v[1];
        wr_sel_nxt   = slot_v[1] ? slot_sel[1]  : o_wr_sel;
        wr_addr_nxt  = slot_v[1] ? slot_dest[1] : o_wr_addr;

        busy_nxt     = o_a_busy;
        if (o_wr_en) begin
            busy_nxt[o_wr_addr] = 1'b0;
        end
        inflight_nxt = o_inflight + 4'(accept) - 4'(o_wr_en);

        if (accept) begin
            busy_nxt[i_issue_dest] = 1'b1;
            if (lat == 4'd1) begin
                wr_en_nxt   = 1'b1;
                wr_sel_nxt  = i_issue_op;
                wr_addr_nxt = i_issue_dest;
            end else begin
                slot_v_nxt[lat - 4'd1]    = 1'b1;
                slot_sel_nxt[lat - 4'd1]  = i_issue_op;
                slot_dest_nxt[lat - 4'd1] = i_issue_dest;
            end
        end

        // A write already on the port this cycle finishes; everything behind it is dropped.
        if (i_flush) begin
            slot_v_nxt   = '0;
            busy_nxt     = '0;
            inflight_nxt = '0;
            wr_en_nxt    = 1'b0;
            wr_sel_nxt   = o_wr_sel;
            wr_addr_nxt  = o_wr_addr;
        end
    end

    // NOTE: the slot table is a few flops rather than a RAM, so it resets with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v     <= '0;
            slot_sel   <= '0;
            slot_dest  <= '{default: '0};
            o_a_busy   <= '0;
            o_inflight <= '0;
            o_wr_en    <= 1'b0;
            o_wr_sel   <= 1'b0;
            o_wr_addr  <= '0;
        end else begin
            slot_v     <= slot_v_nxt;
            slot_sel   <= slot_sel_nxt;
            slot_dest  <= slot_dest_nxt;
            o_a_busy   <= busy_nxt;
            o_inflight <= inflight_nxt;
            o_wr_en    <= wr_en_nxt;
            o_wr_sel   <= wr_sel_nxt;
            o_wr_addr  <= wr_addr_nxt;
        end
    end

endmodule

// File: tb/tb_addr_fu_scheduler.sv
// Directed bench for addr_fu_scheduler (ADD_LAT=2, MUL_LAT=6); cycle n is the period
// after the nth rising edge of a scenario, inputs driven just after the edge, outputs read at negedge.
module tb_addr_fu_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_issue_valid, i_issue_op, i_use_j, i_use_k, i_flush;
    logic [2:0] i_issue_dest, i_issue_j, i_issue_k;
    logic       o_issue_ready, o_wr_en, o_wr_sel;
    logic [2:0] o_wr_addr;
    logic [7:0] o_a_busy;
    logic [3:0] o_inflight;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addr_fu_scheduler #(.ADD_LAT(2), .MUL_LAT(6), .AREG_AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_issue_valid(i_issue_valid), .i_issue_op(i_issue_op),
        .i_issue_dest(i_issue_dest), .i_issue_j(i_issue_j), .i_issue_k(i_issue_k),
        .i_use_j(i_use_j), .i_use_k(i_use_k), .i_flush(i_flush),
        .o_issue_ready(o_issue_ready), .o_wr_en(o_wr_en), .o_wr_sel(o_wr_sel),
        .o_wr_addr(o_wr_addr), .o_a_busy(o_a_busy), .o_inflight(o_inflight)
    );

    task automatic idle();
        i_issue_valid = 1'b0; i_issue_op = 1'b0; i_issue_dest = 3'd0;
        i_issue_j = 3'd0; i_issue_k = 3'd0; i_use_j = 1'b0; i_use_k = 1'b0; i_flush = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [2:0] dest, input logic [2:0] j,
                         input logic [2:0] k, input logic uj, input logic uk);
        i_issue_valid = 1'b1; i_issue_op = op; i_issue_dest = dest;
        i_issue_j = j; i_issue_k = k; i_use_j = uj; i_use_k = uk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", o_wr_en); end
        checks++; if (o_wr_sel !== 1'b0) begin errors++; $display("FAIL reset_wr_sel got %b want 0", o_wr_sel); end
        checks++; if (o_wr_addr !== 3'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", o_wr_addr); end
        checks++; if (o_a_busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h want 00", o_a_busy); end
        checks++; if (o_inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", o_inflight); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL ready_idle_novalid got %b want 1", o_issue_ready); end
        i_issue_valid = 1'b1;
        #1;
        checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL ready_idle_valid got %b want 1", o_issue_ready); end
        idle();
        tick();
    endtask

    task automatic test_single_add();
        for (int c = 0; c <= 4; c++) begin
            idle();
            if (c == 0) issue(1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            if (c == 0) begin
                checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL add_ready c%0d got %b want 1", c, o_issue_ready); end
            end
            checks++; if (o_wr_en !== (c == 2)) begin errors++; $display("FAIL add_wr_en c%0d got %b want %b", c, o_wr_en, (c == 2)); end
            checks++; if (o_a_busy !== ((c == 1 || c == 2) ? 8'h08 : 8'h00)) begin errors++; $display("FAIL add_busy c%0d got %h", c, o_a_busy); end
            checks++; if (o_inflight !== ((c == 1 || c == 2) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL add_inflight c%0d got %0d", c, o_inflight); end
            if (c == 2) begin
                checks++; if (o_wr_sel !== 1'b0 || o_wr_addr !== 3'd3) begin errors++; $display("FAIL add_wr_dest got sel %b addr %0d want sel 0 addr 3", o_wr_sel, o_wr_addr); end
            end
            tick();
        end
    endtask

    task automatic test_port_collision();
        for (int c = 0; c <= 8; c++) begin
            idle();
            if (c == 0) issue(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
            if (c == 4 || c == 5) issue(1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            if (c == 0 || c == 4 || c == 5) begin
                checks++; if (o_issue_ready !== (c != 4)) begin errors++; $display("FAIL coll_ready c%0d got %b want %b", c, o_issue_ready, (c != 4)); end
            end
            checks++; if (o_wr_en !== (c == 6 || c == 7)) begin errors++; $display("FAIL coll_wr_en c%0d got %b", c, o_wr_en); end
            if (c == 6) begin
                checks++; if (o_wr_sel !== 1'b1 || o_wr_addr !== 3'd1) begin errors++; $display("FAIL coll_mul_wr got sel %b addr %0d want sel 1 addr 1", o_wr_sel, o_wr_addr); end
            end
            if (c == 7 || c == 8) begin
                checks++; if (o_wr_sel !== 1'b0 || o_wr_addr !== 3'd2) begin errors++; $display("FAIL coll_add_wr c%0d got sel %b addr %0d want sel 0 addr 2", c, o_wr_sel, o_wr_addr); end
            end
            if (c == 8) begin
                checks++; if (o_inflight !== 4'd0) begin errors++; $display("FAIL coll_drain got %0d want 0", o_inflight); end
            end
            tick();
        end
    endtask

    task automatic test_raw();
        for (int c = 0; c <= 10; c++) begin
            idle();
            if (c == 0) issue(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
            if (c >= 1 && c <= 7) issue(1'b0, 3'd0, 3'd4, 3'd0, 1'b1, 1'b0);
            @(negedge clk);
            if (c >= 1 && c <= 7) begin
                checks++; if (o_issue_ready !== (c == 7)) begin errors++; $display("FAIL raw_ready c%0d got %b want %b", c, o_issue_ready, (c == 7)); end
            end
            if (c == 6) begin
                checks++; if (o_wr_en !== 1'b1 || o_wr_sel !== 1'b1 || o_wr_addr !== 3'd4) begin errors++; $display("FAIL raw_mul_wr got en %b sel %b addr %0d", o_wr_en, o_wr_sel, o_wr_addr); end
            end
            if (c == 9) begin
                checks++; if (o_wr_en !== 1'b1 || o_wr_sel !== 1'b0 || o_wr_addr !== 3'd0) begin errors++; $display("FAIL raw_add_wr got en %b sel %b addr %0d", o_wr_en, o_wr_sel, o_wr_addr); end
            end
            if (c == 10) begin
                checks++; if (o_inflight !== 4'd0) begin errors++; $display("FAIL raw_drain got %0d want 0", o_inflight); end
            end
            tick();
        end
        // Unused operands must not block; self-source dest is fine when not busy.
        for (int c = 0; c <= 7; c++) begin
            idle();
            if (c == 0) issue(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
            if (c == 1) issue(1'b0, 3'd2, 3'd2, 3'd4, 1'b1, 1'b0);
            if (c == 2) issue(1'b0, 3'd5, 3'd0, 3'd4, 1'b0, 1'b1);
            @(negedge clk);
            if (c == 1) begin
                checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL raw_nouse_ready got %b want 1", o_issue_ready); end
            end
            if (c == 2) begin
                checks++; if (o_issue_ready !== 1'b0) begin errors++; $display("FAIL raw_k_ready got %b want 0", o_issue_ready); end
                checks++; if (o_a_busy !== 8'h14) begin errors++; $display("FAIL raw_busy got %h want 14", o_a_busy); end
            end
            if (c == 7) begin
                checks++; if (o_inflight !== 4'd0 || o_a_busy !== 8'h00) begin errors++; $display("FAIL raw2_drain got inflight %0d busy %h", o_inflight, o_a_busy); end
            end
            tick();
        end
    endtask

    task automatic test_waw();
        for (int c = 0; c <= 10; c++) begin
            idle();
            if (c == 0) issue(1'b0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0);
            if (c >= 1 && c <= 3) issue(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                checks++; if (o_issue_ready !== (c == 3)) begin errors++; $display("FAIL waw_ready c%0d got %b want %b", c, o_issue_ready, (c == 3)); end
            end
            checks++; if (o_wr_en !== (c == 2 || c == 9)) begin errors++; $display("FAIL waw_wr_en c%0d got %b", c, o_wr_en); end
            if (c == 9) begin
                checks++; if (o_wr_sel !== 1'b1 || o_wr_addr !== 3'd5) begin errors++; $display("FAIL waw_mul_wr got sel %b addr %0d want sel 1 addr 5", o_wr_sel, o_wr_addr); end
            end
            if (c == 4) begin
                checks++; if (o_a_busy !== 8'h20) begin errors++; $display("FAIL waw_busy got %h want 20", o_a_busy); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int peak = 0;
        for (int c = 0; c <= 11; c++) begin
            int acc, wr;
            idle();
            if (c <= 7) issue(1'b0, 3'(c), 3'd0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            acc = (c < 8) ? c : 8;
            wr  = (c < 2) ? 0 : ((c - 2 > 8) ? 8 : c - 2);
            if (c <= 7) begin
                checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d got %b want 1", c, o_issue_ready); end
            end
            checks++; if (o_wr_en !== (c >= 2 && c <= 9)) begin errors++; $display("FAIL b2b_wr_en c%0d got %b", c, o_wr_en); end
            if (c >= 2 && c <= 9) begin
                checks++; if (o_wr_addr !== 3'(c - 2) || o_wr_sel !== 1'b0) begin errors++; $display("FAIL b2b_wr_addr c%0d got %0d want %0d", c, o_wr_addr, c - 2); end
            end
            checks++; if (o_inflight !== 4'(acc - wr)) begin errors++; $display("FAIL b2b_inflight c%0d got %0d want %0d", c, o_inflight, acc - wr); end
            if (int'(o_inflight) > peak) peak = int'(o_inflight);
            tick();
        end
        checks++; if (peak != 2) begin errors++; $display("FAIL b2b_peak got %0d want 2", peak); end
    endtask

    task automatic test_flush();
        for (int c = 0; c <= 8; c++) begin
            idle();
            if (c == 0) issue(1'b1, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0);
            if (c == 1) issue(1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0);
            if (c == 2) issue(1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0);
            if (c == 3) begin
                issue(1'b0, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0);
                i_flush = 1'b1;
            end
            @(negedge clk);
            if (c == 3) begin
                checks++; if (o_issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", o_issue_ready); end
                checks++; if (o_wr_en !== 1'b1 || o_wr_addr !== 3'd2) begin errors++; $display("FAIL flush_cycle_wr got en %b addr %0d want en 1 addr 2", o_wr_en, o_wr_addr); end
                checks++; if (o_inflight !== 4'd3) begin errors++; $display("FAIL flush_pre_inflight got %0d want 3", o_inflight); end
                checks++; if (o_a_busy !== 8'h4C) begin errors++; $display("FAIL flush_pre_busy got %h want 4c", o_a_busy); end
            end
            if (c >= 4) begin
                checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL flush_wr_en c%0d got %b want 0", c, o_wr_en); end
                checks++; if (o_a_busy !== 8'h00 || o_inflight !== 4'd0) begin errors++; $display("FAIL flush_clear c%0d got busy %h inflight %0d", c, o_a_busy, o_inflight); end
            end
            if (c == 4) begin
                checks++; if (o_wr_addr !== 3'd2) begin errors++; $display("FAIL flush_addr_hold got %0d want 2", o_wr_addr); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 2; c++) begin
            idle();
            if (c == 0) issue(1'b1, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0);
            if (c == 1) issue(1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
            tick();
        end
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (o_wr_en !== 1'b0 || o_wr_addr !== 3'd0 || o_wr_sel !== 1'b0) begin errors++; $display("FAIL rstmid_wr got en %b sel %b addr %0d", o_wr_en, o_wr_sel, o_wr_addr); end
        checks++; if (o_a_busy !== 8'h00 || o_inflight !== 4'd0) begin errors++; $display("FAIL rstmid_state got busy %h inflight %0d", o_a_busy, o_inflight); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            checks++; if (o_wr_en !== 1'b0 || o_inflight !== 4'd0) begin errors++; $display("FAIL rstmid_quiet c%0d got en %b inflight %0d", c, o_wr_en, o_inflight); end
            tick();
        end
        for (int c = 0; c <= 2; c++) begin
            idle();
            if (c == 0) issue(1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (o_wr_en !== (c == 2)) begin errors++; $display("FAIL rstmid_new_wr c%0d got %b", c, o_wr_en); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_single_add();
        test_port_collision();
        test_raw();
        test_waw();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
